// File: rtl/sr_pulse_driver.sv
// Request conditioner for a NAND SR latch: sync + debounce + rising-edge detect per
// channel, then an FSM that emits mutually exclusive fixed-width active-low pulses.

module sr_pulse_chan #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  output logic rise_o
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             filt_prev_q;

  // Counter only survives while the synchronised input keeps disagreeing with the level.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == DB_LAST) filt_d = sync_q[1];
      else                  cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], req_i};
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  assign rise_o = filt_q & ~filt_prev_q;
endmodule

module sr_pulse_driver #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned GAP_W    = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic reset_req,
  output logic sbar,
  output logic rbar,
  output logic busy,
  output logic q_shadow
);
  localparam int unsigned NUM_CH = 2;  // index 0 = set, 1 = reset
  localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GW_LAST = CNT_W'(GAP_W - 1);

  typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;

  logic [NUM_CH-1:0] req, rise, start;
  logic [NUM_CH-1:0] pend_q, pend_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              sbar_q, rbar_q, busy_q;

  assign req = {reset_req, set_req};

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    sr_pulse_chan #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .req_i  (req[g]),
      .rise_o (rise[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if      (pend_q[1]) state_d = RST_P;
        else if (pend_q[0]) state_d = SET_P;
      end
      SET_P, RST_P: begin
        if (cnt_q == PW_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GW_LAST) begin
          cnt_d = '0;
          // Pending work is taken straight from GAP so no idle cycle is inserted.
          if      (pend_q[1]) state_d = RST_P;
          else if (pend_q[0]) state_d = SET_P;
          else                state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    start[0] = (state_d == SET_P) && (state_q != SET_P);
    start[1] = (state_d == RST_P) && (state_q != RST_P);
    q_d      = q_q;
    if (start[0]) q_d = 1'b1;
    if (start[1]) q_d = 1'b0;
    // A fresh edge wins over the clear so it is never lost; a set flag absorbs repeats.
    pend_d = rise | (pend_q & ~start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      q_q     <= 1'b0;
      sbar_q  <= 1'b1;
      rbar_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      q_q     <= q_d;
      sbar_q  <= (state_d != SET_P);
      rbar_q  <= (state_d != RST_P);
      busy_q  <= (state_d != IDLE) || (|pend_d);
    end
  end

  assign sbar     = sbar_q;
  assign rbar     = rbar_q;
  assign busy     = busy_q;
  assign q_shadow = q_q;
endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench: expected pulses (channel, start cycle, width, q_shadow) are queued
// when stimulus is applied and checked by a monitor when the DUT drives them.

module tb_sr_pulse_driver;
  logic clk = 1'b0;
  logic reset, set_req, reset_req;
  logic sbar, rbar, busy, q_shadow;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit ch;      // 1 = set pulse on sbar, 0 = reset pulse on rbar
    int start;
    int width;
    bit q;
  } exp_t;

  exp_t sb[$];

  sr_pulse_driver dut (
    .clk       (clk),
    .reset     (reset),
    .set_req   (set_req),
    .reset_req (reset_req),
    .sbar      (sbar),
    .rbar      (rbar),
    .busy      (busy),
    .q_shadow  (q_shadow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic s_prev = 1'b1, r_prev = 1'b1;
  int   s_start, r_start;
  exp_t cur_s, cur_r;

  task automatic take(input bit ch, output exp_t e);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL unexpected_pulse: observed ch %0d at cycle %0d expected none", ch, cyc);
      e = '{ch, cyc, -1, q_shadow};
    end else begin
      e = sb.pop_front();
      chk("pulse_channel", 32'(ch), 32'(e.ch));
      chk("pulse_start", cyc, e.start);
      chk("q_shadow_at_pulse", 32'(q_shadow), 32'(e.q));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("never_both_low", 32'(sbar | rbar), 1);
    if (s_prev && !sbar) begin
      take(1'b1, e);
      cur_s   = e;
      s_start = cyc;
    end
    if (!s_prev && sbar) chk("sbar_width", cyc - s_start, cur_s.width);
    if (r_prev && !rbar) begin
      take(1'b0, e);
      cur_r   = e;
      r_start = cyc;
    end
    if (!r_prev && rbar) chk("rbar_width", cyc - r_start, cur_r.width);
    s_prev <= sbar;
    r_prev <= rbar;
  end

  // ---------------- stimulus ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset_q", 32'(q_shadow), 0);
    chk("post_reset_busy", 32'(busy), 0);
  endtask

  initial begin
    int e;
    reset = 1'b1; set_req = 1'b1; reset_req = 1'b1;

    // Reset held with both requests high
    repeat (3) begin
      @(negedge clk);
      chk("rst_sbar", 32'(sbar), 1);
      chk("rst_rbar", 32'(rbar), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_q", 32'(q_shadow), 0);
    end
    e = cyc; reset = 1'b0;
    sb.push_back('{1'b0, e + 8, 2, 1'b0});
    sb.push_back('{1'b1, e + 11, 2, 1'b1});
    wait_until(e + 14);
    set_req = 1'b0; reset_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_q", 32'(q_shadow), 1);

    // Single set
    do_reset();
    e = cyc; set_req = 1'b1;
    sb.push_back('{1'b1, e + 8, 2, 1'b1});
    wait_until(e + 6);  chk("single_busy_pre", 32'(busy), 0);
    wait_until(e + 7);  chk("single_busy_pend", 32'(busy), 1);
                        chk("single_q_before", 32'(q_shadow), 0);
    wait_until(e + 8);  chk("single_q_after", 32'(q_shadow), 1);
                        chk("single_sbar_low", 32'(sbar), 0);
    wait_until(e + 10); chk("single_busy_gap", 32'(busy), 1);
    set_req = 1'b0;
    wait_until(e + 11); chk("single_busy_idle", 32'(busy), 0);
    repeat (10) @(negedge clk);

    // Glitch rejection: 3 cycles high, then 4 cycles high
    do_reset();
    e = cyc; set_req = 1'b1;
    wait_until(e + 3); set_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch3_q", 32'(q_shadow), 0);
    chk("glitch3_busy", 32'(busy), 0);
    e = cyc; set_req = 1'b1;
    sb.push_back('{1'b1, e + 8, 2, 1'b1});
    wait_until(e + 4); set_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch4_q", 32'(q_shadow), 1);

    // Simultaneous set and reset: reset first, set after the gap
    do_reset();
    e = cyc; set_req = 1'b1; reset_req = 1'b1;
    sb.push_back('{1'b0, e + 8, 2, 1'b0});
    sb.push_back('{1'b1, e + 11, 2, 1'b1});
    wait_until(e + 10); set_req = 1'b0; reset_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("simul_q", 32'(q_shadow), 1);
    chk("simul_busy", 32'(busy), 0);

    // Back-to-back: reset request pends during the sbar pulse, bounce is absorbed
    e = cyc; set_req = 1'b1;
    sb.push_back('{1'b1, e + 8, 2, 1'b1});
    wait_until(e + 2); reset_req = 1'b1;
    sb.push_back('{1'b0, e + 11, 2, 1'b0});
    wait_until(e + 9);  reset_req = 1'b0;
    wait_until(e + 10); reset_req = 1'b1;
    wait_until(e + 14); set_req = 1'b0; reset_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_q", 32'(q_shadow), 0);
    chk("b2b_busy", 32'(busy), 0);

    // Reset on the second cycle of an sbar pulse
    e = cyc; set_req = 1'b1;
    sb.push_back('{1'b1, e + 8, 1, 1'b1});
    wait_until(e + 8); chk("midp_sbar_low", 32'(sbar), 0);
    reset = 1'b1; set_req = 1'b0;
    wait_until(e + 9);
    chk("midp_sbar", 32'(sbar), 1);
    chk("midp_q", 32'(q_shadow), 0);
    chk("midp_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midp_after_q", 32'(q_shadow), 0);
    chk("midp_after_busy", 32'(busy), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sr_pulse_driver.md
# sr_pulse_driver

Upstream stage for the NAND SR latch. It conditions two raw, asynchronous request inputs (set and reset, typically from push-buttons) with a synchroniser, a debounce filter and rising-edge detection. Each accepted request becomes one active-low pulse of fixed width on `sbar` or `rbar`, which wire directly to the latch's `Sbar`/`Rbar` inputs. By construction, `sbar` and `rbar` are never both low, so the latch's forbidden state cannot occur.

## Interface
- `DEBOUNCE`, default 4: number of consecutive cycles the synchronised input must differ from the filtered level before the filtered level changes; legal range ≥2.
- `PULSE_W`, default 2: number of cycles `sbar` or `rbar` is held low per request; legal range ≥1.
- `GAP_W`, default 1: minimum number of cycles with both outputs high between consecutive pulses; legal range ≥1.
- `CNT_W`, default 8: width of the debounce, pulse and gap counters; must hold max(`DEBOUNCE`, `PULSE_W`, `GAP_W`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `set_req` in 1: raw, asynchronous set request, active-high.
- `reset_req` in 1: raw, asynchronous reset request, active-high.
- `sbar` out 1: active-low set pulse to the latch, registered.
- `rbar` out 1: active-low reset pulse to the latch, registered.
- `busy` out 1: high when the FSM is not IDLE or any request is pending.
- `q_shadow` out 1: expected latch Q after the most recently issued pulse.

## Operation
- Per channel (set, reset) the input path is:
  - two-flop synchroniser;
  - debounce counter;
  - registered filtered level;
  - rising-edge detector (filtered high and its previous-cycle copy low).
- Debounce rule:
  - If the synchronised input equals the filtered level, the counter clears.
  - Otherwise the counter increments.
  - On the `DEBOUNCE`-th consecutive differing cycle, the filtered level takes the synchronised value and the counter clears.
- A detected rising edge sets that channel's pending flag. Falling edges have no effect.
- The pending flag clears on the edge its pulse starts. A flag already set absorbs a further edge, so requests never queue more than one deep per channel.
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE: if `pending_reset`, go to RST_P; else if `pending_set`, go to SET_P; else stay in IDLE.
  - SET_P / RST_P: drive `sbar` / `rbar` low for `PULSE_W` cycles, then go to GAP.
  - GAP: both outputs high for `GAP_W` cycles. Then apply the IDLE priority rule directly (no extra IDLE cycle) if any flag is pending; otherwise go to IDLE.
- Priority: when both requests are pending, reset is served first and set follows after the gap. The two requests are never merged or dropped.
- `q_shadow` is set to 1 on entry to SET_P and to 0 on entry to RST_P. A redundant request (for example set while `q_shadow` is already 1) still produces a pulse.
- Invariant: `sbar` | `rbar` is 1 on every cycle.

## Timing
- Reset values: `sbar`=1, `rbar`=1, `busy`=0, `q_shadow`=0. Synchronisers, filtered levels, counters and pending flags are all 0, and the FSM is in IDLE.
- Reset asserted mid-pulse or mid-gap: outputs return to their reset values after that edge, and pending requests are discarded.
- Latency, with the FSM in IDLE and the first edge sampling `set_req` high counted as edge 0:
  - filtered level high after edge `DEBOUNCE`+1;
  - pending flag set after edge `DEBOUNCE`+2;
  - `sbar` low after edge `DEBOUNCE`+3 (edge 7 at the defaults);
  - `sbar` high again after edge `DEBOUNCE`+3+`PULSE_W`.
- `busy` is a registered output: it rises with the pending flag and falls on the edge the FSM enters IDLE with no flag pending.
- A request arriving during a pulse or gap is served at the end of GAP. The inter-pulse high time is then exactly `GAP_W` cycles.
- A set edge and a reset edge detected on the same cycle give RST_P for `PULSE_W` cycles, then GAP for `GAP_W` cycles, then SET_P. Final `q_shadow`=1.

## Test plan
All scenarios use the default parameters.

- **Reset:** hold `reset` for 3 cycles with both requests high → `sbar`=`rbar`=1, `busy`=0, `q_shadow`=0 throughout; after release, the first pulse appears no earlier than 7 edges later.
- **Single set:** `set_req` high for 10 cycles → `sbar` low after edge 7 for exactly 2 cycles, `q_shadow` goes 0→1, `rbar` stays 1, `busy` returns to 0.
- **Glitch rejection:** `set_req` high for 3 cycles, then low → no pulse, `q_shadow` stays 0. Repeat with 4 cycles high → exactly one pulse.
- **Simultaneous:** `set_req` and `reset_req` rise on the same cycle → `rbar` low for 2 cycles, both high for 1 cycle, then `sbar` low for 2 cycles; final `q_shadow`=1; never both low.
- **Back-to-back:** `reset_req` rises while `sbar` is low → `rbar` pulse starts exactly 1 gap cycle after `sbar` returns high. A second `reset_req` edge during that wait yields only one `rbar` pulse.
- **Reset mid-pulse:** assert `reset` on the second cycle of an `sbar` pulse → `sbar`=1 and `q_shadow`=0 after that edge, and no pulse resumes after release.
